storage_ring_addr: RTL and testbench
====================================

Name: storage_ring_addr

Overview:
- Parametrised address generator for the accumulated-sum storage RAM.
- Holds SLOTS frames of `points` samples each, organised as a ring.
- Write side: streams one frame into the current slot, then advances the ring with wrap-around.
- Read side: streams back a frame selected by lag (1 = most recently completed frame), with base address computed sequentially rather than by multiplier.
- Sits between the accumulator/divider stage (writer) and the ratio stage (reader), driving the storage RAM address/wren pins.

Parameters:
SLOTS, 10, number of frames held in the ring (>=2)
ADDR_W, 15, RAM address width
PT_W, 11, width of points-per-frame value
SLOT_W, $clog2(SLOTS), slot/lag index width (derived, not overridden)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-high reset
points  in  PT_W  samples per frame; sampled on accepted wr_start
flush  in  1  sync clear: aborts both sides, ring emptied
wr_start  in  1  pulse: begin writing the current slot
wr_valid  in  1  one strobe per sample to be written
wren  out  1  RAM write enable
wr_address  out  ADDR_W  RAM write address
wr_done  out  1  pulse with the last wren of a frame
rd_start  in  1  pulse: begin reading the frame selected by rd_lag
rd_lag  in  SLOT_W  frames back from the write slot, legal 1..SLOTS-1
rd_req  in  1  one strobe per sample to be read
rd_address  out  ADDR_W  RAM read address
rd_addr_valid  out  1  rd_address valid this cycle
rd_busy  out  1  read side not idle
rd_done  out  1  pulse with the last rd_addr_valid of a frame
rd_err  out  1  one-cycle pulse: rd_start rejected
cfg_err  out  1  one-cycle pulse: wr_start rejected
slot_idx  out  SLOT_W  current write slot
slots_filled  out  SLOT_W+1  completed frames, saturates at SLOTS

Behaviour:
- Reset: every output 0; wr_slot=0; wr_base=0; slots_filled=0; both FSMs idle. Reset is effective immediately, including mid-frame.
- Idle addresses: wren, rd_addr_valid and both address outputs are 0 whenever not strobed.
- Write FSM, W_IDLE -> W_RUN:
  - Transition on wr_start when points!=0 and SLOTS*points <= 2**ADDR_W.
  - Otherwise pulse cfg_err next cycle and stay in W_IDLE.
  - points is latched on the accepted wr_start; wr_cnt=0.
  - wr_start while in W_RUN is ignored.
- W_RUN:
  - Each wr_valid produces, one cycle later, wren=1 with wr_address=wr_base+wr_cnt; wr_cnt increments.
  - On the wr_valid with wr_cnt==points-1, next cycle: wr_done=1 alongside the last wren.
  - Same cycle: wr_slot advances (SLOTS-1 wraps to 0), wr_base=(wrap ? 0 : wr_base+points), slots_filled=min(slots_filled+1, SLOTS), FSM -> W_IDLE.
- Read FSM, R_IDLE -> R_CALC -> R_RUN -> R_IDLE:
  - rd_start is rejected when rd_lag==0, rd_lag>=SLOTS, rd_lag>slots_filled, or the latched points is 0. A rejected start pulses rd_err next cycle and the FSM stays in R_IDLE.
  - On an accepted start: rd_slot=(wr_slot-rd_lag) mod SLOTS, latched.
  - R_CALC: base accumulates points once per cycle, rd_slot times (0 cycles of accumulation when rd_slot=0). Then -> R_RUN. rd_busy=1 from the cycle after accepted rd_start until rd_done.
  - rd_req in R_IDLE or R_CALC is ignored.
  - R_RUN: each rd_req produces, next cycle, rd_addr_valid=1 with rd_address=rd_base+rd_cnt. After points requests, rd_done pulses with the last valid; FSM -> R_IDLE.
- Write and read run concurrently. Read base/points are latched, so wr_slot advancing mid-read does not affect the read. Lag>=1 guarantees the read slot is never the slot being written.
- flush (registered): both FSMs -> idle, wr_slot=0, wr_base=0, slots_filled=0. No wr_done/rd_done is issued for aborted frames. Strobes are 0 from the cycle after flush.
- Arithmetic: address sums are computed at ADDR_W and never exceed SLOTS*points-1, guaranteed by the cfg check. The cfg product is computed at PT_W+SLOT_W+1 bits.

Decomposition:
- Shared package storage_pkg: write/read state enums; helper function for modulo-SLOTS slot decrement.
- Natural sub-module: storage_base_calc (iterative slot*points accumulator, start/done handshake), reused by the read side.

Test Plan (all with SLOTS=10, ADDR_W=15, points=4):
1. rst, wr_start, 4 wr_valid -> wren at addresses 0,1,2,3 (1-cycle latency); wr_done with address 3; slot_idx=1; slots_filled=1.
2. 11 frames -> slot 9 writes 36..39; 11th frame writes 0..3; slots_filled saturates at 10; slot_idx=1.
3. After 3 frames, rd_start with rd_lag=1 -> rd_busy; then 4 rd_req -> rd_address 8,9,10,11; rd_done on 11. Concurrent frame 4 writes 12..15 unaffected.
4. After the wrap of test 2 (wr_slot=1), rd_lag=2 -> slot 9, addresses 36..39.
5. Rejections:
   - rd_lag=3 with slots_filled=2 -> rd_err pulse, no rd_addr_valid.
   - rd_lag=0 -> rd_err.
   - points=0 -> cfg_err, no wren.
   - points=4000 (40000>32768) -> cfg_err, no wren.
6. Aborts:
   - flush after 2 wr_valid -> no wren from next cycle, slot_idx=0, slots_filled=0, no wr_done.
   - rst asserted mid-read -> all outputs 0 immediately.

Source files
------------

// File: rtl/storage_pkg.sv
// Shared types for the storage ring address generator.
// Write/read FSM states and a ring slot-decrement helper.
package storage_pkg;

  typedef enum logic {
    W_IDLE,
    W_RUN
  } wr_state_e;

  typedef enum logic [1:0] {
    R_IDLE,
    R_CALC,
    R_RUN
  } rd_state_e;

  // (slot - lag) mod slots, for 0 <= slot < slots and 0 < lag < slots
  function automatic int slot_dec(
    input int slot,
    input int lag,
    input int slots
  );
    return (slot >= lag) ? slot - lag : slot + slots - lag;
  endfunction

endpackage

// File: rtl/storage_base_calc.sv
// Iterative slot*step accumulator: one add per cycle, no multiplier.
// Ports: clr aborts, start loads count/step, done holds base valid.
module storage_base_calc #(
  parameter int ADDR_W = 15,
  parameter int PT_W   = 11,
  parameter int SLOT_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              start,
  input  logic [SLOT_W-1:0] count,
  input  logic [PT_W-1:0]   step,
  output logic              done,
  output logic [ADDR_W-1:0] base
);

  logic              busy_q, busy_d;
  logic [SLOT_W-1:0] left_q, left_d;
  logic [PT_W-1:0]   step_q, step_d;
  logic [ADDR_W-1:0] acc_q, acc_d;

  assign done = busy_q && (left_q == '0);
  assign base = acc_q;

  always_comb begin
    busy_d = busy_q;
    left_d = left_q;
    step_d = step_q;
    acc_d  = acc_q;
    if (clr) begin
      busy_d = 1'b0;
      left_d = '0;
      acc_d  = '0;
    end else if (start) begin
      busy_d = 1'b1;
      left_d = count;
      step_d = step;
      acc_d  = '0;
    end else if (busy_q) begin
      if (left_q == '0) begin
        busy_d = 1'b0;
      end else begin
        acc_d  = acc_q + ADDR_W'(step_q);
        left_d = left_q - SLOT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q <= 1'b0;
      left_q <= '0;
      step_q <= '0;
      acc_q  <= '0;
    end else begin
      busy_q <= busy_d;
      left_q <= left_d;
      step_q <= step_d;
      acc_q  <= acc_d;
    end
  end

endmodule

// File: rtl/storage_ring_addr.sv
// Ring-of-frames address generator for the accumulated-sum RAM.
// Write side: wr_start/wr_valid -> wren/wr_address/wr_done, cfg_err.
// Read side: rd_start/rd_lag/rd_req -> rd_address/rd_addr_valid,
// rd_busy/rd_done/rd_err. Status: slot_idx, slots_filled. flush clears.
module storage_ring_addr
  import storage_pkg::*;
#(
  parameter int SLOTS  = 10,
  parameter int ADDR_W = 15,
  parameter int PT_W   = 11,
  localparam int SLOT_W = $clog2(SLOTS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [PT_W-1:0]   points,
  input  logic              flush,
  input  logic              wr_start,
  input  logic              wr_valid,
  output logic              wren,
  output logic [ADDR_W-1:0] wr_address,
  output logic              wr_done,
  input  logic              rd_start,
  input  logic [SLOT_W-1:0] rd_lag,
  input  logic              rd_req,
  output logic [ADDR_W-1:0] rd_address,
  output logic              rd_addr_valid,
  output logic              rd_busy,
  output logic              rd_done,
  output logic              rd_err,
  output logic              cfg_err,
  output logic [SLOT_W-1:0] slot_idx,
  output logic [SLOT_W:0]   slots_filled
);

  localparam int PW = PT_W + SLOT_W + 1;
  localparam int CW = (PW > ADDR_W + 1) ? PW : ADDR_W + 1;
  localparam logic [CW-1:0] CFG_LIM = CW'(1) << ADDR_W;
  localparam logic [SLOT_W:0] FULL = (SLOT_W+1)'(SLOTS);
  localparam logic [SLOT_W-1:0] LAST = SLOT_W'(SLOTS - 1);

  wr_state_e         wr_state_q, wr_state_d;
  logic [SLOT_W-1:0] wr_slot_q, wr_slot_d;
  logic [ADDR_W-1:0] wr_base_q, wr_base_d;
  logic [SLOT_W:0]   filled_q, filled_d;
  logic [PT_W-1:0]   pts_q, pts_d;
  logic [PT_W-1:0]   wr_cnt_q, wr_cnt_d;
  logic              wren_q, wren_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic              wr_done_q, wr_done_d;
  logic              cfg_err_q, cfg_err_d;

  rd_state_e         rd_state_q, rd_state_d;
  logic [PT_W-1:0]   rd_pts_q, rd_pts_d;
  logic [PT_W-1:0]   rd_cnt_q, rd_cnt_d;
  logic [ADDR_W-1:0] rd_base_q, rd_base_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic              rd_vld_q, rd_vld_d;
  logic              rd_done_q, rd_done_d;
  logic              rd_err_q, rd_err_d;

  logic [PW-1:0]     cfg_prod;
  logic              cfg_ok;
  logic              rd_bad;
  logic              calc_start;
  logic              calc_done;
  logic [ADDR_W-1:0] calc_base;
  logic [SLOT_W-1:0] calc_count;

  assign cfg_prod = PW'(SLOTS) * PW'(points);
  assign cfg_ok = (points != '0) && (CW'(cfg_prod) <= CFG_LIM);

  assign rd_bad = (rd_lag == '0)
               || ({1'b0, rd_lag} >= FULL)
               || ({1'b0, rd_lag} > filled_q)
               || (pts_q == '0);

  assign calc_count = SLOT_W'(slot_dec(
    int'(wr_slot_q), int'(rd_lag), SLOTS));

  storage_base_calc #(
    .ADDR_W (ADDR_W),
    .PT_W   (PT_W),
    .SLOT_W (SLOT_W)
  ) u_base_calc (
    .clk   (clk),
    .rst   (rst),
    .clr   (flush),
    .start (calc_start),
    .count (calc_count),
    .step  (pts_q),
    .done  (calc_done),
    .base  (calc_base)
  );

  always_comb begin
    wr_state_d = wr_state_q;
    wr_slot_d  = wr_slot_q;
    wr_base_d  = wr_base_q;
    filled_d   = filled_q;
    pts_d      = pts_q;
    wr_cnt_d   = wr_cnt_q;
    wren_d     = 1'b0;
    wr_addr_d  = '0;
    wr_done_d  = 1'b0;
    cfg_err_d  = 1'b0;
    if (flush) begin
      wr_state_d = W_IDLE;
      wr_slot_d  = '0;
      wr_base_d  = '0;
      filled_d   = '0;
      wr_cnt_d   = '0;
    end else begin
      unique case (wr_state_q)
        W_IDLE: begin
          if (wr_start) begin
            if (cfg_ok) begin
              pts_d      = points;
              wr_cnt_d   = '0;
              wr_state_d = W_RUN;
            end else begin
              cfg_err_d = 1'b1;
            end
          end
        end
        W_RUN: begin
          if (wr_valid) begin
            wren_d    = 1'b1;
            wr_addr_d = wr_base_q + ADDR_W'(wr_cnt_q);
            wr_cnt_d  = wr_cnt_q + PT_W'(1);
            if (wr_cnt_q == pts_q - PT_W'(1)) begin
              wr_done_d  = 1'b1;
              wr_state_d = W_IDLE;
              if (wr_slot_q == LAST) begin
                wr_slot_d = '0;
                wr_base_d = '0;
              end else begin
                wr_slot_d = wr_slot_q + SLOT_W'(1);
                wr_base_d = wr_base_q + ADDR_W'(pts_q);
              end
              if (filled_q != FULL) begin
                filled_d = filled_q + (SLOT_W+1)'(1);
              end
            end
          end
        end
        default: wr_state_d = W_IDLE;
      endcase
    end
  end

  always_comb begin
    rd_state_d = rd_state_q;
    rd_pts_d   = rd_pts_q;
    rd_cnt_d   = rd_cnt_q;
    rd_base_d  = rd_base_q;
    rd_addr_d  = '0;
    rd_vld_d   = 1'b0;
    rd_done_d  = 1'b0;
    rd_err_d   = 1'b0;
    calc_start = 1'b0;
    if (flush) begin
      rd_state_d = R_IDLE;
      rd_cnt_d   = '0;
    end else begin
      unique case (rd_state_q)
        R_IDLE: begin
          if (rd_start) begin
            if (rd_bad) begin
              rd_err_d = 1'b1;
            end else begin
              calc_start = 1'b1;
              rd_pts_d   = pts_q;
              rd_cnt_d   = '0;
              rd_state_d = R_CALC;
            end
          end
        end
        R_CALC: begin
          if (calc_done) begin
            rd_base_d  = calc_base;
            rd_state_d = R_RUN;
          end
        end
        R_RUN: begin
          if (rd_req) begin
            rd_vld_d  = 1'b1;
            rd_addr_d = rd_base_q + ADDR_W'(rd_cnt_q);
            rd_cnt_d  = rd_cnt_q + PT_W'(1);
            if (rd_cnt_q == rd_pts_q - PT_W'(1)) begin
              rd_done_d  = 1'b1;
              rd_state_d = R_IDLE;
            end
          end
        end
        default: rd_state_d = R_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_state_q <= W_IDLE;
      wr_slot_q  <= '0;
      wr_base_q  <= '0;
      filled_q   <= '0;
      pts_q      <= '0;
      wr_cnt_q   <= '0;
      wren_q     <= 1'b0;
      wr_addr_q  <= '0;
      wr_done_q  <= 1'b0;
      cfg_err_q  <= 1'b0;
      rd_state_q <= R_IDLE;
      rd_pts_q   <= '0;
      rd_cnt_q   <= '0;
      rd_base_q  <= '0;
      rd_addr_q  <= '0;
      rd_vld_q   <= 1'b0;
      rd_done_q  <= 1'b0;
      rd_err_q   <= 1'b0;
    end else begin
      wr_state_q <= wr_state_d;
      wr_slot_q  <= wr_slot_d;
      wr_base_q  <= wr_base_d;
      filled_q   <= filled_d;
      pts_q      <= pts_d;
      wr_cnt_q   <= wr_cnt_d;
      wren_q     <= wren_d;
      wr_addr_q  <= wr_addr_d;
      wr_done_q  <= wr_done_d;
      cfg_err_q  <= cfg_err_d;
      rd_state_q <= rd_state_d;
      rd_pts_q   <= rd_pts_d;
      rd_cnt_q   <= rd_cnt_d;
      rd_base_q  <= rd_base_d;
      rd_addr_q  <= rd_addr_d;
      rd_vld_q   <= rd_vld_d;
      rd_done_q  <= rd_done_d;
      rd_err_q   <= rd_err_d;
    end
  end

  assign wren          = wren_q;
  assign wr_address    = wr_addr_q;
  assign wr_done       = wr_done_q;
  assign cfg_err       = cfg_err_q;
  assign rd_address    = rd_addr_q;
  assign rd_addr_valid = rd_vld_q;
  assign rd_done       = rd_done_q;
  assign rd_err        = rd_err_q;
  assign rd_busy       = (rd_state_q != R_IDLE);
  assign slot_idx      = wr_slot_q;
  assign slots_filled  = filled_q;

endmodule

// File: tb/tb_storage_ring_addr.sv
// Scoreboard bench for storage_ring_addr (SLOTS=10, ADDR_W=15).
// Stimulus pushes expected strobes; a negedge monitor pops and compares.
module tb_storage_ring_addr;

  localparam int SLOTS  = 10;
  localparam int ADDR_W = 15;
  localparam int PT_W   = 12;
  localparam int SLOT_W = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic [PT_W-1:0]   points;
  logic              flush;
  logic              wr_start;
  logic              wr_valid;
  logic              wren;
  logic [ADDR_W-1:0] wr_address;
  logic              wr_done;
  logic              rd_start;
  logic [SLOT_W-1:0] rd_lag;
  logic              rd_req;
  logic [ADDR_W-1:0] rd_address;
  logic              rd_addr_valid;
  logic              rd_busy;
  logic              rd_done;
  logic              rd_err;
  logic              cfg_err;
  logic [SLOT_W-1:0] slot_idx;
  logic [SLOT_W:0]   slots_filled;

  storage_ring_addr #(
    .SLOTS  (SLOTS),
    .ADDR_W (ADDR_W),
    .PT_W   (PT_W)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .points        (points),
    .flush         (flush),
    .wr_start      (wr_start),
    .wr_valid      (wr_valid),
    .wren          (wren),
    .wr_address    (wr_address),
    .wr_done       (wr_done),
    .rd_start      (rd_start),
    .rd_lag        (rd_lag),
    .rd_req        (rd_req),
    .rd_address    (rd_address),
    .rd_addr_valid (rd_addr_valid),
    .rd_busy       (rd_busy),
    .rd_done       (rd_done),
    .rd_err        (rd_err),
    .cfg_err       (cfg_err),
    .slot_idx      (slot_idx),
    .slots_filled  (slots_filled)
  );

  always #5 clk = ~clk;

  typedef struct {
    int addr;
    bit done;
  } exp_t;

  exp_t wq[$];
  exp_t rq[$];
  int checks = 0;
  int failures = 0;
  int m_slot, m_filled, m_pts;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_clear();
    m_slot = 0;
    m_filled = 0;
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (wren) begin
        if (wq.size() == 0) begin
          check("unexpected_wren", 1, 0);
        end else begin
          exp_t e;
          e = wq.pop_front();
          check("wr_address", int'(wr_address), e.addr);
          check("wr_done", int'(wr_done), int'(e.done));
        end
      end else begin
        check("wr_idle", int'(wr_address) + int'(wr_done), 0);
      end
      if (rd_addr_valid) begin
        if (rq.size() == 0) begin
          check("unexpected_rd_valid", 1, 0);
        end else begin
          exp_t e;
          e = rq.pop_front();
          check("rd_address", int'(rd_address), e.addr);
          check("rd_done", int'(rd_done), int'(e.done));
        end
      end else begin
        check("rd_idle", int'(rd_address) + int'(rd_done), 0);
      end
    end
  end

  task automatic wr_try(input int p, output bit ok);
    ok = (p != 0) && (SLOTS * p <= (1 << ADDR_W));
    wr_start = 1'b1;
    points = PT_W'(p);
    tick();
    wr_start = 1'b0;
    check("cfg_err", int'(cfg_err), int'(!ok));
    if (ok) m_pts = p;
  endtask

  task automatic wr_frame(input int p, input int gap);
    bit ok;
    int base;
    wr_try(p, ok);
    if (!ok) begin
      wr_valid = 1'b1;
      tick();
      tick();
      wr_valid = 1'b0;
      tick();
      return;
    end
    base = m_slot * m_pts;
    for (int i = 0; i < p; i++) begin
      repeat ($urandom_range(0, gap)) tick();
      wr_valid = 1'b1;
      wq.push_back('{base + i, i == p - 1});
      tick();
      wr_valid = 1'b0;
    end
    m_slot = (m_slot + 1) % SLOTS;
    if (m_filled < SLOTS) m_filled++;
    check("slot_idx", int'(slot_idx), m_slot);
    check("slots_filled", int'(slots_filled), m_filled);
    tick();
  endtask

  task automatic rd_frame(input int lag, input int gap);
    bit ok;
    int p, base;
    ok = (lag != 0) && (lag < SLOTS) && (lag <= m_filled)
      && (m_pts != 0);
    p = m_pts;
    base = ((m_slot - lag + SLOTS) % SLOTS) * p;
    rd_start = 1'b1;
    rd_lag = SLOT_W'(lag);
    tick();
    rd_start = 1'b0;
    check("rd_err", int'(rd_err), int'(!ok));
    check("rd_busy_start", int'(rd_busy), int'(ok));
    rd_req = 1'b1;
    tick();
    rd_req = 1'b0;
    if (!ok) begin
      tick();
      return;
    end
    repeat (11) tick();
    for (int i = 0; i < p; i++) begin
      repeat ($urandom_range(0, gap)) tick();
      rd_req = 1'b1;
      rq.push_back('{base + i, i == p - 1});
      tick();
      rd_req = 1'b0;
    end
    tick();
    check("rd_busy_end", int'(rd_busy), 0);
  endtask

  task automatic do_flush();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    model_clear();
    check("flush_slot", int'(slot_idx), 0);
    check("flush_filled", int'(slots_filled), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    bit ok;
    rst = 1'b0;
    points = '0;
    flush = 1'b0;
    wr_start = 1'b0;
    wr_valid = 1'b0;
    rd_start = 1'b0;
    rd_lag = '0;
    rd_req = 1'b0;
    m_pts = 0;
    model_clear();
    #2 rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_wren", int'(wren), 0);
    check("rst_rd_valid", int'(rd_addr_valid), 0);
    check("rst_busy", int'(rd_busy), 0);
    check("rst_slot", int'(slot_idx), 0);
    check("rst_filled", int'(slots_filled), 0);
    rst = 1'b0;
    tick();

    wr_frame(4, 0);
    check("t1_slot", int'(slot_idx), 1);
    check("t1_filled", int'(slots_filled), 1);

    repeat (10) wr_frame(4, 1);
    check("t2_slot", int'(slot_idx), 1);
    check("t2_filled", int'(slots_filled), 10);

    rd_frame(2, 1);

    do_flush();
    wr_frame(4, 0);
    wr_frame(4, 0);
    rd_frame(3, 0);
    rd_frame(0, 0);

    wr_frame(4, 0);
    fork
      wr_frame(4, 1);
      rd_frame(1, 0);
    join
    check("t3_slot", int'(slot_idx), 4);

    wr_frame(0, 0);
    wr_frame(4000, 0);
    wr_frame(3277, 0);
    wr_try(3276, ok);
    do_flush();

    repeat (4) begin
      int p, n;
      do_flush();
      p = $urandom_range(1, 40);
      n = $urandom_range(1, 13);
      for (int f = 0; f < n; f++) begin
        wr_frame(p, 2);
        if ($urandom_range(0, 1) == 1)
          rd_frame($urandom_range(0, 12), 2);
      end
    end

    do_flush();
    wr_try(4, ok);
    for (int i = 0; i < 2; i++) begin
      wr_valid = 1'b1;
      wq.push_back('{i, 1'b0});
      tick();
    end
    wr_valid = 1'b0;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    model_clear();
    wr_valid = 1'b1;
    tick();
    tick();
    wr_valid = 1'b0;
    tick();
    check("fl_slot", int'(slot_idx), 0);
    check("fl_filled", int'(slots_filled), 0);

    wr_frame(4, 0);
    wr_frame(4, 0);
    rd_start = 1'b1;
    rd_lag = SLOT_W'(1);
    tick();
    rd_start = 1'b0;
    repeat (12) tick();
    rd_req = 1'b1;
    rq.push_back('{4, 1'b0});
    tick();
    rq.push_back('{5, 1'b0});
    tick();
    check("mid_valid", int'(rd_addr_valid), 1);
    #2 rst = 1'b1;
    #1;
    check("ar_valid", int'(rd_addr_valid), 0);
    check("ar_addr", int'(rd_address), 0);
    check("ar_busy", int'(rd_busy), 0);
    check("ar_wren", int'(wren) + int'(wr_address), 0);
    check("ar_flags", int'(rd_done) + int'(rd_err)
      + int'(cfg_err) + int'(wr_done), 0);
    check("ar_slot", int'(slot_idx) + int'(slots_filled), 0);
    rd_req = 1'b0;
    rq.delete();
    wq.delete();
    m_pts = 0;
    model_clear();
    repeat (2) tick();
    rst = 1'b0;
    repeat (3) tick();

    check("wq_left", wq.size(), 0);
    check("rq_left", rq.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
